// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - LSB-first serial-in/parallel-out receiver with valid/ready word port
module serial_deserializer #(
  parameter int N = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          s_in,
  input  logic          s_valid,
  output logic [N-1:0]  word_out,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sh;
  logic [N-1:0]   word_nxt;
  logic           shift_en;
  logic           done;
  logic           load;
  logic           drop;

  // clear outranks s_valid, so a bit arriving with clear never counts
  assign shift_en = s_valid & ~clear;
  assign done     = shift_en & (bit_cnt == CW'(N - 1));
  assign word_nxt = {s_in, sh[N-1:1]};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (done) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (done) begin
          if (word_ready) load = 1'b1;
          else            drop = 1'b1;
        end else if (word_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      sh       <= '0;
      bit_cnt  <= '0;
      word_out <= '0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) word_out <= word_nxt;
      if (clear) begin
        sh      <= '0;
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else begin
        if (shift_en) begin
          sh      <= word_nxt;
          bit_cnt <= done ? '0 : bit_cnt + CW'(1);
        end
        if (drop) overrun <= 1'b1;
      end
    end
  end

  assign word_valid = (state == FULL);

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - directed stimulus with a word-level reference model for serial_deserializer
module tb_serial_deserializer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         s_in = 1'b0;
  logic         s_valid = 1'b0;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic [2:0]   bit_cnt;
  logic         overrun;

  int total = 0;
  int passed = 0;

  serial_deserializer #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .s_in       (s_in),
    .s_valid    (s_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference: bits are placed by index into an accumulator; a word is
  // delivered when the N-th bit lands, or counted as lost if the port is busy.
  int           m_cnt, n_cnt;
  logic [N-1:0] m_acc, n_acc, m_word, n_word, w;
  logic         m_valid, n_valid, m_ovr, n_ovr, done;

  always_comb begin
    n_cnt   = m_cnt;
    n_acc   = m_acc;
    n_word  = m_word;
    n_valid = m_valid;
    n_ovr   = m_ovr;
    done    = 1'b0;
    w       = '0;
    if (clear) begin
      n_cnt = 0;
      n_acc = '0;
      n_ovr = 1'b0;
    end else if (s_valid) begin
      n_acc[m_cnt] = s_in;
      if (m_cnt == N - 1) begin
        done  = 1'b1;
        w     = n_acc;
        n_cnt = 0;
        n_acc = '0;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end
    if (done) begin
      if (!m_valid || word_ready) begin
        n_word  = w;
        n_valid = 1'b1;
      end else begin
        n_ovr = 1'b1;
      end
    end else if (m_valid && word_ready) begin
      n_valid = 1'b0;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt   <= 0;
      m_acc   <= '0;
      m_word  <= '0;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      m_cnt   <= n_cnt;
      m_acc   <= n_acc;
      m_word  <= n_word;
      m_valid <= n_valid;
      m_ovr   <= n_ovr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("model_word_valid", 32'(word_valid), 32'(m_valid));
      check("model_word_out", 32'(word_out), 32'(m_word));
      check("model_bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      check("model_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends a word LSB first; gap > 0 inserts up to that many idle cycles between bits
  task automatic send_word(input logic [N-1:0] d, input int gap);
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_in    = d[i];
      tick();
      s_valid = 1'b0;
      if (gap > 0 && i < N - 1) repeat ($urandom_range(0, gap)) tick();
    end
  endtask

  task automatic send_bits(input logic [N-1:0] d, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      s_valid = 1'b1;
      s_in    = d[i];
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #1;
    check("reset_word_valid", 32'(word_valid), 32'd0);
    check("reset_word_out", 32'(word_out), 32'd0);
    check("reset_bit_cnt", 32'(bit_cnt), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: consecutive bits, consumer always ready
    word_ready = 1'b1;
    send_bits(8'hA5, 3);
    check("t1_bit_cnt_mid", 32'(bit_cnt), 32'd3);
    send_bits(8'hA5 >> 3, 5);
    check("t1_word_out", 32'(word_out), 32'hA5);
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_bit_cnt_wrap", 32'(bit_cnt), 32'd0);
    tick();
    check("t1_valid_pulse", 32'(word_valid), 32'd0);

    // 2: gapped bits
    send_word(8'h3C, 3);
    check("t2_word_out", 32'(word_out), 32'h3C);
    check("t2_valid", 32'(word_valid), 32'd1);
    tick();

    // 3: consumer stalled, second word is lost
    word_ready = 1'b0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    check("t3_word_held", 32'(word_out), 32'h11);
    check("t3_overrun", 32'(overrun), 32'd1);
    word_ready = 1'b1;
    tick();
    check("t3_valid_drop", 32'(word_valid), 32'd0);
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t3_overrun_cleared", 32'(overrun), 32'd0);

    // 4: ready coincides with the next completion
    word_ready = 1'b0;
    send_word(8'h11, 0);
    send_bits(8'h22, 7);
    word_ready = 1'b1;
    send_bits(8'h22 >> 7, 1);
    check("t4_word_out", 32'(word_out), 32'h22);
    check("t4_valid_held", 32'(word_valid), 32'd1);
    check("t4_overrun", 32'(overrun), 32'd0);
    tick();

    // 5: clear mid-word, with overrun set and a word pending
    word_ready = 1'b0;
    send_word(8'h55, 0);
    send_word(8'h66, 0);
    send_bits(8'h05, 3);
    clear   = 1'b1;
    s_valid = 1'b1;
    s_in    = 1'b1;
    tick();
    clear   = 1'b0;
    s_valid = 1'b0;
    check("t5_bit_cnt", 32'(bit_cnt), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    check("t5_word_kept", 32'(word_out), 32'h55);
    check("t5_valid_kept", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    tick();
    send_word(8'hF0, 2);
    check("t5_word_out", 32'(word_out), 32'hF0);

    // 6: reset mid-word with a word pending
    word_ready = 1'b0;
    send_word(8'h99, 0);
    send_bits(8'h1F, 5);
    reset = 1'b1;
    #1;
    check("t6_word_valid", 32'(word_valid), 32'd0);
    check("t6_word_out", 32'(word_out), 32'd0);
    check("t6_bit_cnt", 32'(bit_cnt), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b0;
    word_ready = 1'b1;
    send_word(8'hC3, 0);
    check("t6_word_after", 32'(word_out), 32'hC3);
    check("t6_valid_after", 32'(word_valid), 32'd1);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
